// File: rtl/gts_ack_if.sv
// gts_ack_if: inducer/reporter signal bundle for the gts_ack toggle switch.
//   IPTG : set request from the stimulus source (may be asynchronous to clk)
//   aTc  : clear request from the stimulus source (may be asynchronous to clk)
//   GFP  : registered toggle state, 1 = on
//   ack  : registered acknowledge of a completed request
// Modports:
//   master : stimulus side (drives IPTG/aTc, observes GFP/ack)
//   slave  : switch side (gts_ack)
interface gts_ack_if;
  logic IPTG;
  logic aTc;
  logic GFP;
  logic ack;

  modport master (
    output IPTG,
    output aTc,
    input  GFP,
    input  ack
  );

  modport slave (
    input  IPTG,
    input  aTc,
    output GFP,
    output ack
  );
endinterface

// File: rtl/gts_ack.sv
// gts_ack: synchronous genetic toggle switch with a four-phase acknowledge handshake.
// An IPTG request sets GFP, an aTc request clears it. A request must be held, alone, for the
// settling time; the result is then registered together with ack, and ack is held until
// both inducers are withdrawn.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (GFP=0, ack=0, FSM idle, counter and syncs cleared)
//   bus   : gts_ack_if.slave (IPTG, aTc in; GFP, ack out)
// Parameter:
//   SETTLE_CYCLES : settling delay in cycles after a valid request is seen, 1..255
// Build option:
//   GTS_ACK_SYNC_EN : when defined, IPTG and aTc pass through two-flop synchronizers
//                     (adds two cycles of latency); otherwise inputs must be synchronous.
module gts_ack #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input logic       clk,
  input logic       rst_n,
  gts_ack_if.slave  bus
);

  localparam int unsigned CntW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StAck
  } state_e;

  // Qualified requests seen by the FSM.
  logic iptg_s;
  logic atc_s;

`ifdef GTS_ACK_SYNC_EN
  logic [1:0] iptg_sync_q, iptg_sync_d;
  logic [1:0] atc_sync_q, atc_sync_d;

  always_comb begin
    iptg_sync_d = {iptg_sync_q[0], bus.IPTG};
    atc_sync_d  = {atc_sync_q[0], bus.aTc};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iptg_sync_q <= 2'b00;
      atc_sync_q  <= 2'b00;
    end else begin
      iptg_sync_q <= iptg_sync_d;
      atc_sync_q  <= atc_sync_d;
    end
  end

  assign iptg_s = iptg_sync_q[1];
  assign atc_s  = atc_sync_q[1];
`else
  assign iptg_s = bus.IPTG;
  assign atc_s  = bus.aTc;
`endif

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            req_set_q, req_set_d;  // 1: pending request is IPTG, 0: aTc
  logic            gfp_q, gfp_d;
  logic            ack_q, ack_d;

  // Recorded request still held and the opposing inducer absent.
  logic req_hold;
  assign req_hold = req_set_q ? (iptg_s && !atc_s) : (atc_s && !iptg_s);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_set_d = req_set_q;
    gfp_d     = gfp_q;
    ack_d     = ack_q;

    case (state_q)
      StIdle: begin
        // Exactly one inducer present starts a request; conflicting or no input is ignored.
        if (iptg_s ^ atc_s) begin
          req_set_d = iptg_s;
          cnt_d     = CntLoad;
          state_d   = StSettle;
        end
      end

      StSettle: begin
        if (!req_hold) begin
          // Request withdrawn or contradicted before settling: drop it, state untouched.
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          gfp_d   = req_set_q;
          ack_d   = 1'b1;
          state_d = StAck;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StAck: begin
        // Any inducer still present keeps the handshake open; new requests are ignored.
        if (!iptg_s && !atc_s) begin
          ack_d   = 1'b0;
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        ack_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      req_set_q <= 1'b0;
      gfp_q     <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_set_q <= req_set_d;
      gfp_q     <= gfp_d;
      ack_q     <= ack_d;
    end
  end

  assign bus.GFP = gfp_q;
  assign bus.ack = ack_q;

endmodule

// File: tb/tb_gts_ack.sv
// tb_gts_ack: table-driven self-checking bench for gts_ack (SETTLE_CYCLES = 4).
// Each table record is one clock cycle: inputs driven after the falling edge, expected
// GFP/ack pushed to a scoreboard queue, then popped and compared 1 time unit after the
// rising edge. Records with rst_n low are also checked right after driving, since reset
// acts without a clock edge. Latencies follow S (sync depth) from GTS_ACK_SYNC_EN.
module tb_gts_ack;

  localparam int unsigned Sc = 4;
`ifdef GTS_ACK_SYNC_EN
  localparam int unsigned S = 2;
`else
  localparam int unsigned S = 0;
`endif
  localparam int unsigned L = S + Sc;  // edges from first raw sample to GFP/ack update

  typedef struct packed {
    logic        rst_n;
    logic        ip;
    logic        at;
    logic        gfp;
    logic        ack;
    logic [63:0] tag;
  } vec_t;

  logic clk;
  logic rst_n;

  gts_ack_if bus ();

  gts_ack #(
    .SETTLE_CYCLES(Sc)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t       vecs[$];
  logic [1:0] exp_q[$];
  int         n_cmp;
  int         n_fail;

  function automatic void add(input logic r, input logic ip, input logic at,
                              input logic eg, input logic ea, input logic [63:0] tag);
    vec_t v;
    v.rst_n = r;
    v.ip    = ip;
    v.at    = at;
    v.gfp   = eg;
    v.ack   = ea;
    v.tag   = tag;
    vecs.push_back(v);
  endfunction

  // Full handshake: hold request through the update edge, then withdraw.
  function automatic void handshake(input logic ip, input logic at,
                                    input logic gfp_before, input logic gfp_after);
    for (int j = 0; j < int'(L); j++) add(1'b1, ip, at, gfp_before, 1'b0, "settle");
    for (int j = 0; j < 3; j++) add(1'b1, ip, at, gfp_after, 1'b1, "ack");
    for (int j = 0; j < int'(S); j++) add(1'b1, 1'b0, 1'b0, gfp_after, 1'b1, "ackhold");
    for (int j = 0; j < 2; j++) add(1'b1, 1'b0, 1'b0, gfp_after, 1'b0, "release");
  endfunction

  function automatic void build();
    // Reset held with IPTG high, then released with inputs low.
    for (int j = 0; j < 3; j++) add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "rst");
    for (int j = 0; j < 3; j++) add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "rstidle");
    // Set, then a too-short aTc pulse must leave GFP=1.
    handshake(1'b1, 1'b0, 1'b0, 1'b1);
    for (int j = 0; j < 3; j++) add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "shortatc");
    for (int j = 0; j < int'(S) + 3; j++) add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "shortatc");
    // Clear, then a too-short IPTG pulse must leave GFP=0.
    handshake(1'b0, 1'b1, 1'b1, 1'b0);
    for (int j = 0; j < 3; j++) add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "shortipt");
    for (int j = 0; j < int'(S) + 3; j++) add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "shortipt");
    // Both inducers together from idle.
    for (int j = 0; j < 8; j++) add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "both");
    for (int j = 0; j < int'(S) + 2; j++) add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "both");
    // aTc joins while IPTG is settling.
    for (int j = 0; j < 2; j++) add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "abort");
    for (int j = 0; j < int'(L) + 2; j++) add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "abort");
    for (int j = 0; j < int'(S) + 2; j++) add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "abort");
    // aTc raised while acknowledged for IPTG is ignored.
    for (int j = 0; j < int'(L); j++) add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "ign");
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "ign");
    for (int j = 0; j < 4; j++) add(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "ignboth");
    for (int j = 0; j < 3; j++) add(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, "ignatc");
    for (int j = 0; j < int'(S); j++) add(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "ignhold");
    for (int j = 0; j < 2; j++) add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "ignrel");
    // Reset during an aTc settle (GFP=1 before).
    for (int j = 0; j < int'(S) + 2; j++) add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "setlrst");
    for (int j = 0; j < 2; j++) add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "setlrst");
    for (int j = 0; j < 2; j++) add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "setlrst");
    handshake(1'b1, 1'b0, 1'b0, 1'b1);
    // Reset while acknowledged.
    for (int j = 0; j < int'(L); j++) add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "ackrst");
    for (int j = 0; j < 2; j++) add(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "ackrst");
    for (int j = 0; j < 2; j++) add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "ackrst");
    for (int j = 0; j < 2; j++) add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "ackrst");
    handshake(1'b1, 1'b0, 1'b0, 1'b1);
  endfunction

  task automatic check(input int idx, input logic [63:0] tag);
    logic [1:0] got;
    logic [1:0] want;
    got  = {bus.GFP, bus.ack};
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %0s vec %0d: GFP,ack = %b, required %b", tag, idx, got, want);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.IPTG = 1'b0;
    bus.aTc  = 1'b0;
    build();
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n    = vecs[i].rst_n;
      bus.IPTG = vecs[i].ip;
      bus.aTc  = vecs[i].at;
      if (!vecs[i].rst_n) begin
        #1;
        exp_q.push_back(2'b00);
        check(i, vecs[i].tag);
      end
      exp_q.push_back({vecs[i].gfp, vecs[i].ack});
      @(posedge clk);
      #1;
      check(i, vecs[i].tag);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
